// File: rtl/sub_pkg.sv
// rtl/sub_pkg.sv - shared types, defaults and saturation constants for chunked_subtractor
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_CHUNK_W = 8;
  localparam int SUB_MAX_W   = 256;

  // Callers slice the low WIDTH bits of these wide constants.
  function automatic logic [SUB_MAX_W-1:0] sat_max(input int width);
    logic [SUB_MAX_W-1:0] one;
    one = SUB_MAX_W'(1);
    return (one << (width - 1)) - one;
  endfunction

  function automatic logic [SUB_MAX_W-1:0] sat_min(input int width);
    logic [SUB_MAX_W-1:0] one;
    one = SUB_MAX_W'(1);
    return one << (width - 1);
  endfunction

endpackage

// File: rtl/chunk_adder_slice.sv
// rtl/chunk_adder_slice.sv - combinational W-bit adder with carry in/out
module chunk_adder_slice #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         carry_in,
  output logic [W-1:0] sum,
  output logic         carry_out
);

  assign {carry_out, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, carry_in};

endmodule

// File: rtl/chunked_subtractor.sv
// rtl/chunked_subtractor.sv - handshaked multi-cycle subtractor, CHUNK_W bits per cycle
// Optional output clamping on signed overflow: define SUB_SATURATE_EN.
module chunked_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int CHUNK_W = DEF_CHUNK_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             borrow,
  output logic             overflow,
  output logic             zero
);

  localparam int NCHUNK = WIDTH / CHUNK_W;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NCHUNK - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic             carry_q, carry_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             a_msb_q, a_msb_d, b_msb_q, b_msb_d;
  logic             in_ready_d, out_valid_d, borrow_d, overflow_d, zero_d;
  logic [WIDTH-1:0] out_d;

  logic [CHUNK_W-1:0] sum;
  logic               cout;
  logic [WIDTH-1:0]   diff, final_out;
  logic               ovf;

  // Operand registers shift right each RUN cycle, so the slice always sees the low chunk.
  chunk_adder_slice #(.W(CHUNK_W)) u_slice (
    .a         (a_q[CHUNK_W-1:0]),
    .b         (b_q[CHUNK_W-1:0]),
    .carry_in  (carry_q),
    .sum       (sum),
    .carry_out (cout)
  );

  assign diff = (res_q >> CHUNK_W) | (WIDTH'(sum) << (WIDTH - CHUNK_W));
  assign ovf  = (a_msb_q != b_msb_q) && (diff[WIDTH-1] != a_msb_q);

`ifdef SUB_SATURATE_EN
  localparam logic [SUB_MAX_W-1:0] SAT_MAX_W = sat_max(WIDTH);
  localparam logic [SUB_MAX_W-1:0] SAT_MIN_W = sat_min(WIDTH);
  localparam logic [WIDTH-1:0]     SAT_MAX   = SAT_MAX_W[WIDTH-1:0];
  localparam logic [WIDTH-1:0]     SAT_MIN   = SAT_MIN_W[WIDTH-1:0];
  assign final_out = ovf ? (a_msb_q ? SAT_MIN : SAT_MAX) : diff;
`else
  assign final_out = diff;
`endif

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    carry_d     = carry_q;
    idx_d       = idx_q;
    a_msb_d     = a_msb_q;
    b_msb_d     = b_msb_q;
    out_valid_d = out_valid;
    out_d       = out;
    borrow_d    = borrow;
    overflow_d  = overflow;
    zero_d      = zero;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          a_d     = op1;
          b_d     = ~op2;
          carry_d = 1'b1;
          idx_d   = '0;
          a_msb_d = op1[WIDTH-1];
          b_msb_d = op2[WIDTH-1];
          state_d = RUN;
        end
      end
      RUN: begin
        res_d   = diff;
        a_d     = a_q >> CHUNK_W;
        b_d     = b_q >> CHUNK_W;
        carry_d = cout;
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == LAST) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          out_d       = final_out;
          borrow_d    = ~cout;
          overflow_d  = ovf;
          zero_d      = (final_out == '0);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      carry_q   <= 1'b0;
      idx_q     <= '0;
      a_msb_q   <= 1'b0;
      b_msb_q   <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out       <= '0;
      borrow    <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      res_q     <= res_d;
      carry_q   <= carry_d;
      idx_q     <= idx_d;
      a_msb_q   <= a_msb_d;
      b_msb_q   <= b_msb_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      out       <= out_d;
      borrow    <= borrow_d;
      overflow  <= overflow_d;
      zero      <= zero_d;
    end
  end

endmodule

// File: tb/tb_chunked_subtractor.sv
// tb/tb_chunked_subtractor.sv - directed self-checking bench for chunked_subtractor
module tb_chunked_subtractor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] op1 = '0;
  logic [31:0] op2 = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out;
  logic        borrow, overflow, zero;

  int errors = 0;
  int checks = 0;

  chunked_subtractor #(.WIDTH(32), .CHUNK_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op1       (op1),
    .op2       (op2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .borrow    (borrow),
    .overflow  (overflow),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Returns at the negedge following the accept edge; operands are then scrambled.
  task automatic send(input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", {31'd0, in_ready}, 32'd1);
    op1 = a;
    op2 = b;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    op1 = 32'hA5A5_5A5A;
    op2 = 32'h0F0F_F0F0;
  endtask

  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] e_out, input logic e_b, input logic e_o, input logic e_z);
    send(a, b);
    repeat (3) @(negedge clk);
    check({tag, "_early_valid"}, {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_out"}, out, e_out);
    check({tag, "_flags"}, {29'd0, borrow, overflow, zero}, {29'd0, e_b, e_o, e_z});
    @(negedge clk);
    check({tag, "_released"}, {30'd0, out_valid, in_ready}, 32'd1);
  endtask

  logic [31:0] sat_exp1, sat_exp2;
  int spurious;

  initial begin
`ifdef SUB_SATURATE_EN
    sat_exp1 = 32'h8000_0000;
    sat_exp2 = 32'h7FFF_FFFF;
`else
    sat_exp1 = 32'h7FFF_FFFF;
    sat_exp2 = 32'h8000_0000;
`endif
    #12;
    check("rst_outputs", {26'd0, in_ready, out_valid, borrow, overflow, zero, |out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready_low", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    check("rst_in_ready_rise", {31'd0, in_ready}, 32'd1);

    do_op("sub10_3",   32'd10,          32'd3,          32'd7,          1'b0, 1'b0, 1'b0);
    do_op("ripple",    32'h0000_0100,   32'd1,          32'h0000_00FF,  1'b0, 1'b0, 1'b0);
    do_op("neg",       32'd3,           32'd10,         32'hFFFF_FFF9,  1'b1, 1'b0, 1'b0);
    do_op("ovf_neg",   32'h8000_0000,   32'd1,          sat_exp1,       1'b0, 1'b1, 1'b0);
    do_op("ovf_pos",   32'd0,           32'h8000_0000,  sat_exp2,       1'b1, 1'b1, 1'b0);
    do_op("equal",     32'h1234_5678,   32'h1234_5678,  32'd0,          1'b0, 1'b0, 1'b1);
    do_op("op2_zero",  32'hDEAD_BEEF,   32'd0,          32'hDEAD_BEEF,  1'b0, 1'b0, 1'b0);

    out_ready = 1'b0;
    send(32'd10, 32'd3);
    repeat (4) @(negedge clk);
    check("bp_valid", {31'd0, out_valid}, 32'd1);
    op1 = 32'd100;
    op2 = 32'd1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_out", out, 32'd7);
      check("bp_hold_ctl", {28'd0, out_valid, in_ready, borrow, zero}, 32'b1000);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release", {30'd0, out_valid, in_ready}, 32'd1);
    do_op("after_bp", 32'd100, 32'd1, 32'd99, 1'b0, 1'b0, 1'b0);

    send(32'd1, 32'd2);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_outputs", {26'd0, in_ready, out_valid, borrow, overflow, zero, |out}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    spurious = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) spurious++;
    end
    check("abort_no_valid", spurious, 32'd0);
    do_op("after_abort", 32'd5, 32'd9, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/chunked_subtractor.md
Name: chunked_subtractor

Overview:
- Multi-cycle, handshaked two-operand subtractor; the inverse operation to the team's combinational 32-bit adder.
- Computes op1 − op2 CHUNK_W bits per cycle, rippling a carry between chunks.
- Reports borrow, signed-overflow and zero flags alongside the difference.
- Sits on the datapath where a registered, flow-controlled arithmetic stage replaces an unregistered adder path.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of CHUNK_W.
- CHUNK_W, 8, bits processed per RUN cycle; NCHUNK = WIDTH/CHUNK_W (4 at defaults).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept operands.
- op1  input  WIDTH  minuend.
- op2  input  WIDTH  subtrahend.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out  output  WIDTH  difference.
- borrow  output  1  unsigned borrow (op1 < op2).
- overflow  output  1  signed overflow.
- zero  output  1  out == 0.

Behaviour:
- Interface: one clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset values: in_ready=0, out_valid=0, out=0, borrow=0, overflow=0, zero=0; state=IDLE. in_ready is registered and rises on the first clk edge after rst_n deasserts.
- States and transitions:
  - IDLE: in_ready=1. On in_valid&in_ready at edge T, capture op1 and ~op2, set carry=1 and chunk index=0, clear in_ready, go to RUN.
  - RUN: at each edge, compute chunk i = op1[i] + ~op2[i] + carry and store it; carry takes the chunk carry-out. After NCHUNK edges, go to DONE.
  - DONE: out_valid=1 from edge T+NCHUNK. Hold until out_valid&out_ready, then go to IDLE at that edge.
- Latency: out_valid asserts NCHUNK cycles after the accept edge. Minimum accept-to-accept spacing is NCHUNK+2 cycles.
- Operand capture: operands are sampled only at accept. Input changes after accept are ignored.
- Arithmetic:
  - out = (op1 − op2) mod 2^WIDTH.
  - borrow = ~final carry.
  - overflow = (op1[MSB]≠op2[MSB]) && (out[MSB]≠op1[MSB]).
  - zero = (out==0), evaluated on the final (possibly saturated) out.
- Backpressure: while out_valid && !out_ready, out and all flags hold stable, in_ready=0, and in_valid is ignored.
- Output when idle: out and flags keep their last value after the handshake; consumers qualify them with out_valid.
- Reset mid-operation: asserting rst_n low in any state aborts the operation immediately. No out_valid is produced for the aborted operand pair.
- Boundary results: op1==op2 gives zero=1, borrow=0. op2=0 gives out=op1, borrow=0.

Optional Feature:
- Macro: SUB_SATURATE_EN.
- Defined: when overflow=1, out is clamped to 2^(WIDTH−1)−1 if op1 is non-negative, or to −2^(WIDTH−1) if op1 is negative. overflow still reports 1 and borrow is unaffected. Clamping happens in the RUN→DONE transition, so latency is unchanged.
- Undefined: out wraps modulo 2^WIDTH.

Decomposition:
- Shared package sub_pkg:
  - state enum (IDLE, RUN, DONE);
  - default WIDTH/CHUNK_W;
  - functions returning the signed max/min saturation constants for a given WIDTH.
- One sub-module: chunk_adder_slice, a combinational CHUNK_W-bit adder with carry_in/carry_out. Instantiate it once and reuse it across RUN cycles.

Test Plan (WIDTH=32, CHUNK_W=8):
- op1=10, op2=3 accepted at edge T → out_valid at T+4, out=7, borrow=0, overflow=0, zero=0.
- op1=0x00000100, op2=1 (borrow ripples across a chunk) → out=0x000000FF, borrow=0. op1=3, op2=10 → out=0xFFFFFFF9, borrow=1, overflow=0.
- op1=0x80000000, op2=1 → out=0x7FFFFFFF, overflow=1, borrow=0. With SUB_SATURATE_EN defined: out=0x80000000, overflow=1, zero=0.
- op1=op2=0x12345678 → out=0, zero=1, borrow=0, overflow=0.
- Hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands → out and flags stable, in_ready=0, new operands not captured. After out_ready=1: IDLE, then the next op is accepted and its result is correct.
- rst_n pulsed low 2 cycles after accept → all outputs 0 immediately, no out_valid for the aborted op. The following op (5−9) gives out=0xFFFFFFFC, borrow=1.
